// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: multiply/divide op encoding and unit FSM states.
package cpu_types_pkg;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared HI/LO accumulator: radix-2 add-then-shift multiply
// or restoring shift-subtract divide, selected by div_mode.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    borrow  = (shifted < {1'b0, opnd});
    // On no-borrow the true difference is below the divisor, so W bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (div_mode) begin
      nxt_hi = borrow ? shifted[WIDTH-1:0] : diff;
      nxt_lo = {acc_lo[WIDTH-2:0], ~borrow};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; fixed WIDTH+1 cycle latency,
// sign handled by magnitude arithmetic plus a final correction cycle.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [1:0]       op_bits;
  logic             a_neg;
  logic             b_neg;
  logic             accept;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign op_bits = op;
  assign a_neg   = ~op_bits[0] & a[WIDTH-1];
  assign b_neg   = ~op_bits[0] & b[WIDTH-1];
  assign a_mag   = cond_neg(a, a_neg);
  assign b_mag   = cond_neg(b, b_neg);
  assign accept  = (state == MD_IDLE) && start && !flush;
  assign busy    = (state != MD_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo),
    .opnd     (opnd),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  // Divide by zero leaves the dividend magnitude in acc_hi, so the normal
  // remainder fix-up already reproduces a; only the quotient is forced.
  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (is_div) begin
      fix_lo = dz ? '1 : cond_neg(acc_lo, neg_q);
      fix_hi = cond_neg(acc_hi, neg_r);
    end else begin
      {fix_hi, fix_lo} = cond_neg2({acc_hi, acc_lo}, neg_q);
    end
  end

  // Datapath accumulator: loaded on accept, iterated while running.
  always_ff @(posedge CLK) begin
    if (accept) begin
      acc_hi <= '0;
      acc_lo <= op_bits[1] ? a_mag : b_mag;
      opnd   <= op_bits[1] ? b_mag : a_mag;
    end else if (state == MD_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  // Control FSM and architectural HI/LO.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            state  <= MD_RUN;
            cnt    <= CNT_W'(WIDTH);
            is_div <= op_bits[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= (b == '0);
          end
        end
        MD_RUN: begin
          if (flush) begin
            state <= MD_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= dz & is_div;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: driver queues expected results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         start;
  muldiv_op_t   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
    string        name;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_mis = 0;
  int           cyc = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (done) begin
      check("busy_with_done", 32'(busy), 32'd0);
      if (q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done", hi, lo);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_hi"}, hi, mon_e.hi);
        check({mon_e.name, "_lo"}, lo, mon_e.lo);
        check({mon_e.name, "_dz"}, 32'(div_by_zero), 32'(mon_e.dz));
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Call at a negedge; returns at the negedge following the sampling edge.
  task automatic issue(input muldiv_op_t o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                       input string nm, input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge CLK);
    #1;
    if (push) begin
      e.hi   = eh;
      e.lo   = el;
      e.dz   = ed;
      e.cyc  = cyc + W + 1;
      e.name = nm;
      q.push_back(e);
      last_hi = eh;
      last_lo = el;
    end
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s_idle: got busy=%0d pending=%0d after 200 cycles, required idle", nm, busy, q.size());
    end
  endtask

  task automatic run_vec(input muldiv_op_t o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input string nm);
    issue(o, aa, bb, eh, el, ed, nm, 1'b1);
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit seen;
    nRST  = 1'b0;
    start = 1'b0;
    op    = MD_MULT;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    nRST = 1'b1;
    @(negedge CLK);

    run_vec(MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mult_m1x2");
    run_vec(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, "multu_ffx2");
    run_vec(MD_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_7xm3");
    run_vec(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minsq");
    run_vec(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_maxsq");
    run_vec(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7d2");
    run_vec(MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, "divu_7d2");
    run_vec(MD_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, "div_100dm7");
    run_vec(MD_DIV,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, "div_m100d7");
    run_vec(MD_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0, "divu_maxd10");
    run_vec(MD_DIVU,  32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000, 1'b0, "divu_3d7");
    run_vec(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_minbym1");
    run_vec(MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, "divu_5d0");
    run_vec(MD_DIV,   32'hFFFFFFFA, 32'h00000000, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, "div_m6d0");

    // MTLO in IDLE
    lo_we = 1'b1;
    wdata = 32'h00001234;
    @(negedge CLK);
    lo_we = 1'b0;
    check("lo_we_lo", lo, 32'h00001234);
    check("lo_we_hi", hi, last_hi);
    last_lo = 32'h00001234;

    // A second start mid-RUN must be ignored: exactly one done follows.
    issue(MD_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, "multu_3x5", 1'b1);
    repeat (9) @(negedge CLK);
    start = 1'b1;
    op    = MD_DIVU;
    a     = 32'h00000009;
    b     = 32'h00000000;
    @(negedge CLK);
    start = 1'b0;
    wait_idle("midrun_start");
    repeat (40) @(negedge CLK);

    // MTHI in RUN takes effect, MTHI in FIX loses to the result.
    issue(MD_DIVU, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, "divu_hiwe", 1'b1);
    repeat (4) @(negedge CLK);
    hi_we = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge CLK);
    hi_we = 1'b0;
    check("hi_we_run", hi, 32'hA5A5A5A5);
    repeat (27) @(negedge CLK);
    hi_we = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge CLK);
    hi_we = 1'b0;
    wait_idle("divu_hiwe");

    // Back-to-back: second start presented in the done cycle.
    issue(MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "b2b_first", 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", 32'(seen), 32'd1);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "b2b_second", 1'b1);
    wait_idle("b2b_second");

    // Flush at cycle 10 of a MULT: no done, HI/LO retained.
    issue(MD_MULT, 32'h00012345, 32'h00000010, 32'h0, 32'h0, 1'b0, "flush_mult", 1'b0);
    repeat (8) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge CLK);
    check("flush_hi", hi, last_hi);
    check("flush_lo", lo, last_lo);

    // Flush with start in IDLE: start ignored.
    flush = 1'b1;
    start = 1'b1;
    op    = MD_MULT;
    a     = 32'h3;
    b     = 32'h3;
    @(negedge CLK);
    flush = 1'b0;
    start = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge CLK);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    issue(MD_MULTU, 32'h00000003, 32'h00000004, 32'h0, 32'h0, 1'b0, "abort_multu", 1'b0);
    repeat (3) @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    last_hi = '0;
    last_lo = '0;
    @(negedge CLK);
    run_vec(MD_MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0, "post_reset_6x7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
